// File: rtl/program_counter_if.sv
// Fetch-side bus between the program counter and the redirect/fetch logic.
// The pc_misaligned signal exists only when PC_ALIGN_CHECK_EN is defined.
interface program_counter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] present_val;
    logic             load_en;
    logic [WIDTH-1:0] pc_out;
`ifdef PC_ALIGN_CHECK_EN
    logic             pc_misaligned;
`endif

    // The datapath that issues redirects and consumes the PC.
    modport master (
        output present_val,
        output load_en,
`ifdef PC_ALIGN_CHECK_EN
        input  pc_misaligned,
`endif
        input  pc_out
    );

    // The PC register itself.
    modport slave (
        input  present_val,
        input  load_en,
`ifdef PC_ALIGN_CHECK_EN
        output pc_misaligned,
`endif
        output pc_out
    );
endinterface

// File: rtl/program_counter.sv
// Instruction address register: loads a redirect target or steps by INCREMENT each edge.
// Optional macro PC_ALIGN_CHECK_EN forces loaded targets word-aligned and flags misaligned loads.
module program_counter #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int               INCREMENT    = 4
) (
    input logic                clk,
    input logic                reset_n,
    program_counter_if.slave   pc_bus
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] load_target;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q;

    assign load_target = {pc_bus.present_val[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= pc_bus.load_en && (pc_bus.present_val[1:0] != 2'b00);
        end
    end

    assign pc_bus.pc_misaligned = misaligned_q;
`else
    assign load_target = pc_bus.present_val;
`endif

    // reset_n is active-high despite its name; reset outranks a same-cycle load.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            pc_q <= RESET_VECTOR;
        end else if (pc_bus.load_en) begin
            pc_q <= load_target;
        end else begin
            pc_q <= pc_q + STEP;
        end
    end

    assign pc_bus.pc_out = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a per-cycle reference model and literal checkpoints.
module tb_program_counter;
    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    program_counter_if #(.WIDTH(WIDTH)) bus ();

    program_counter #(
        .WIDTH(WIDTH),
        .RESET_VECTOR(RV),
        .INCREMENT(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pc_bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the PC must be after each edge, from the operating rules.
    logic [31:0] exp_pc;
    logic        exp_mis;
    bit          model_valid;

    initial begin
        model_valid = 1'b0;
        exp_pc      = '0;
        exp_mis     = 1'b0;
    end

    always @(posedge clk) begin
        exp_mis = 1'b0;
        if (reset_n) begin
            exp_pc      = RV;
            model_valid = 1'b1;
        end else if (bus.load_en) begin
`ifdef PC_ALIGN_CHECK_EN
            exp_pc  = bus.present_val & 32'hFFFF_FFFC;
            exp_mis = (bus.present_val % 4) != 0;
`else
            exp_pc  = bus.present_val;
`endif
        end else begin
            exp_pc = 32'((64'(exp_pc) + 64'd4) % 64'h1_0000_0000);
        end
        #1;
        if (model_valid) begin
            total++;
            if (bus.pc_out !== exp_pc) begin
                bad++;
                $display("FAIL model_pc t=%0t got=%h want=%h", $time, bus.pc_out, exp_pc);
            end
`ifdef PC_ALIGN_CHECK_EN
            total++;
            if (bus.pc_misaligned !== exp_mis) begin
                bad++;
                $display("FAIL model_mis t=%0t got=%b want=%b", $time, bus.pc_misaligned, exp_mis);
            end
`endif
        end
    end

    // Drive one edge's inputs, then pin the resulting PC to a hand-computed literal.
    task automatic step(input logic rst, input logic ld, input logic [31:0] val,
                        input logic [31:0] want, input string name);
        @(negedge clk);
        reset_n         = rst;
        bus.load_en     = ld;
        bus.present_val = val;
        @(posedge clk);
        #2;
        total++;
        if (bus.pc_out !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, bus.pc_out, want);
        end
    endtask

    task automatic check_mis(input logic want, input string name);
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if (bus.pc_misaligned !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, bus.pc_misaligned, want);
        end
`else
        if (want === 1'bx) $display("unused %s", name);
`endif
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset_n         = 1'b1;
        bus.load_en     = 1'b1;
        bus.present_val = 32'h1234;

        step(1'b1, 1'b1, 32'h1234, 32'h0, "reset_edge1");
        check_mis(1'b0, "reset_mis");
        step(1'b1, 1'b1, 32'h1234, 32'h0, "reset_edge2");

        step(1'b0, 1'b0, 32'h1234, 32'h4, "inc_1");
        step(1'b0, 1'b0, 32'hDEAD, 32'h8, "inc_2");
        step(1'b0, 1'b0, 32'h0, 32'hC, "inc_3");

        step(1'b0, 1'b1, 32'h10, 32'h10, "load_10");
        step(1'b0, 1'b0, 32'h10, 32'h14, "after_load_1");
        step(1'b0, 1'b0, 32'h99, 32'h18, "after_load_2");

        step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "load_top");
        step(1'b0, 1'b0, 32'h0, 32'h0, "wrap");

        step(1'b0, 1'b0, 32'h0, 32'h4, "pre_stall");
        step(1'b0, 1'b1, 32'h4, 32'h4, "stall_1");
        step(1'b0, 1'b1, 32'h4, 32'h4, "stall_2");

        step(1'b0, 1'b1, 32'h40, 32'h40, "load_40");
        step(1'b1, 1'b1, 32'h80, 32'h0, "reset_beats_load");
        check_mis(1'b0, "reset_mis_mid");
        step(1'b0, 1'b0, 32'h80, 32'h4, "release");

        step(1'b0, 1'b1, 32'hA5A5_5A58, 32'hA5A5_5A58, "load_pattern");
        step(1'b0, 1'b0, 32'h0, 32'hA5A5_5A5C, "pattern_inc");

`ifdef PC_ALIGN_CHECK_EN
        step(1'b0, 1'b1, 32'h103, 32'h100, "align_load");
        check_mis(1'b1, "align_mis_set");
        step(1'b0, 1'b0, 32'h103, 32'h104, "align_inc");
        check_mis(1'b0, "align_mis_clr");
`else
        step(1'b0, 1'b1, 32'h103, 32'h103, "verbatim_load");
        step(1'b0, 1'b0, 32'h0, 32'h107, "verbatim_inc");
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
